// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory controller
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;
    localparam int TIMEOUT_W = 8;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: size decode, byte enables, store replication, misalign check and load extract/extend
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  off,
    input  logic        is_byte,
    input  logic        is_hwrd,
    input  logic        is_wrd,
    input  logic [31:0] wdata,
    input  logic [1:0]  ld_off,
    input  logic [1:0]  ld_size,
    input  logic        ld_rdu,
    input  logic [31:0] rdata,
    output logic [1:0]  size,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misalign,
    output logic [31:0] ld_data
);
    logic [31:0] s;
    always_comb begin
        // an explicit word flag and no size flag at all both mean word
        size = is_byte ? SZ_B : is_hwrd ? SZ_H : is_wrd ? SZ_W : SZ_W;
        be = size == SZ_B ? BE_B << off : size == SZ_H ? BE_H << off : BE_W;
        wdata_rep = size == SZ_B ? {4{wdata[7:0]}} : size == SZ_H ? {2{wdata[15:0]}} : wdata;
        misalign = (size == SZ_H && off[0]) || (size == SZ_W && off != 2'b00);
        s = rdata >> {ld_off, 3'b000};
        ld_data = ld_size == SZ_B ? {{24{s[7] & ~ld_rdu}}, s[7:0]} :
                  ld_size == SZ_H ? {{16{s[15] & ~ld_rdu}}, s[15:0]} : s;
    end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: turns the mem stage's single-cycle dmem request into a valid/ready word-bus transaction,
// stalling the pipeline until the access completes, faults or times out.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic        dmem_write,
    input  logic        dmem_read,
    input  logic        dmem_rdu,
    input  logic        dmem_byte,
    input  logic        dmem_hwrd,
    input  logic        dmem_wrd,
    output logic [31:0] dmem_rdata,
    output logic        dmem_stall,
    output logic        dmem_misalign,
    output logic        dmem_fault,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    output logic        bus_we,
    output logic        bus_valid,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rvalid,
    input  logic        bus_err
);
    state_t state, state_nx;
    logic [TIMEOUT_W-1:0] cnt;
    logic [1:0] size, ld_off, ld_size;
    logic [3:0] be;
    logic [31:0] wdata_rep, ld_data;
    logic misalign, ld_rdu, fault_q, fault_nx, req, accept, expire, start;
    dmem_lane_align u_align (
        .off       (dmem_addr[1:0]),
        .is_byte   (dmem_byte),
        .is_hwrd   (dmem_hwrd),
        .is_wrd    (dmem_wrd),
        .wdata     (dmem_wdata),
        .ld_off    (ld_off),
        .ld_size   (ld_size),
        .ld_rdu    (ld_rdu),
        .rdata     (bus_rdata),
        .size      (size),
        .be        (be),
        .wdata_rep (wdata_rep),
        .misalign  (misalign),
        .ld_data   (ld_data)
    );
    assign req = dmem_read | dmem_write;
    assign start = state == IDLE && req && !misalign;
    assign accept = bus_valid & bus_ready;
    // the increment made in this cycle would reach TIMEOUT, so abort on this edge
    assign expire = (state == REQ || state == RESP) && cnt == TIMEOUT_W'(TIMEOUT - 1);
    assign bus_valid = state == REQ;
    assign dmem_stall = start || state == REQ || state == RESP;
    assign dmem_misalign = state == IDLE && req && misalign;
    assign dmem_fault = state == DONE && fault_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        fault_nx = 1'b0;
        case (state)
            IDLE: state_nx = start ? REQ : IDLE;
            REQ: begin
                state_nx = accept ? (bus_we ? DONE : RESP) : expire ? DONE : REQ;
                fault_nx = accept ? bus_we & bus_err : expire;
            end
            RESP: begin
                state_nx = (bus_rvalid || expire) ? DONE : RESP;
                fault_nx = bus_rvalid ? bus_err : expire;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_addr <= '0;
            bus_wdata <= '0;
            bus_be <= '0;
            bus_we <= 1'b0;
            ld_off <= '0;
            ld_size <= '0;
            ld_rdu <= 1'b0;
            cnt <= '0;
            fault_q <= 1'b0;
            dmem_rdata <= '0;
        end else begin
            if (start) begin
                bus_addr <= {dmem_addr[31:2], 2'b00};
                bus_wdata <= wdata_rep;
                bus_be <= be;
                bus_we <= dmem_write;
                ld_off <= dmem_addr[1:0];
                ld_size <= size;
                ld_rdu <= dmem_rdu;
                cnt <= '0;
            end else if (state == REQ || state == RESP) begin
                cnt <= cnt + 1'b1;
            end
            // stores, faults and timeouts all complete with zero load data
            if (state != DONE && state_nx == DONE) begin
                fault_q <= fault_nx;
                dmem_rdata <= (state == RESP && bus_rvalid && !bus_err) ? ld_data : '0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scenario tasks against a scoreboard of expected per-access results
module tb_dmem_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] dmem_addr = '0, dmem_wdata = '0, bus_rdata = '0;
    logic dmem_write = 0, dmem_read = 0, dmem_rdu = 0, dmem_byte = 0, dmem_hwrd = 0, dmem_wrd = 0;
    logic bus_ready = 0, bus_rvalid = 0, bus_err = 0;
    logic [31:0] dmem_rdata, bus_addr, bus_wdata;
    logic [3:0] bus_be;
    logic dmem_stall, dmem_misalign, dmem_fault, bus_we, bus_valid;
    int checks = 0, errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic        we;
        logic        fault;
        logic        fault_next;
        logic        misalign;
        logic        unstable;
        int          stall;
        int          valid;
    } obs_t;
    obs_t sb[$];

    dmem_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_write(dmem_write), .dmem_read(dmem_read),
        .dmem_rdu(dmem_rdu), .dmem_byte(dmem_byte), .dmem_hwrd(dmem_hwrd), .dmem_wrd(dmem_wrd),
        .dmem_rdata(dmem_rdata), .dmem_stall(dmem_stall), .dmem_misalign(dmem_misalign), .dmem_fault(dmem_fault),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_we(bus_we), .bus_valid(bus_valid),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors + 1);
        $fatal(1);
    end

    // Bus responder: ready after `waits` valid cycles (never if negative), rvalid `rlat` cycles after a read accept.
    task automatic run_access(input logic [31:0] a, input logic [31:0] wd, input logic wr, input logic rd,
                              input logic u, input logic b, input logic h, input logic w,
                              input int waits, input int rlat, input logic [31:0] rsp, input logic err,
                              output obs_t o);
        int vcnt = 0, rcnt = 0;
        bit acc_rd = 0, fin = 0;
        o = '{default: 0};
        for (int k = 0; k < 40 && !fin; k++) begin
            @(posedge clk); #1;
            bus_ready = 0; bus_rvalid = 0; bus_err = 0;
            if (k == 0) begin
                dmem_addr = a; dmem_wdata = wd; dmem_write = wr; dmem_read = rd;
                dmem_rdu = u; dmem_byte = b; dmem_hwrd = h; dmem_wrd = w; bus_rdata = rsp;
            end
            if (acc_rd) rcnt++;
            #1;
            if (dmem_misalign) o.misalign = 1;
            if (bus_valid) begin
                if (vcnt == 0) begin
                    o.addr = bus_addr; o.wdata = bus_wdata; o.be = bus_be; o.we = bus_we;
                end else if (bus_addr !== o.addr || bus_wdata !== o.wdata || bus_be !== o.be || bus_we !== o.we) begin
                    o.unstable = 1;
                end
                vcnt++;
                if (waits >= 0 && vcnt > waits) begin
                    bus_ready = 1;
                    bus_err = err & bus_we;
                    if (!bus_we) acc_rd = 1;
                end
            end
            if (acc_rd && rcnt > rlat) begin
                bus_rvalid = 1;
                bus_err = err;
            end
            if (dmem_stall) o.stall++;
            else begin
                fin = 1;
                o.rdata = dmem_rdata;
                o.fault = dmem_fault;
            end
        end
        o.valid = vcnt;
        @(posedge clk); #1;
        dmem_read = 0; dmem_write = 0; bus_ready = 0; bus_rvalid = 0; bus_err = 0;
        #1 o.fault_next = dmem_fault;
    endtask

    task automatic test_reset();
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus_valid); end
        checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus_we); end
        checks++; if ({bus_addr, bus_wdata, bus_be} !== 68'h0) begin errors++; $display("FAIL reset_bus: got %h/%h/%h expected 0", bus_addr, bus_wdata, bus_be); end
        checks++; if (dmem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", dmem_rdata); end
        checks++; if ({dmem_fault, dmem_stall, dmem_misalign} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {dmem_fault, dmem_stall, dmem_misalign}); end
    endtask

    task automatic test_load_byte();
        obs_t o, e;
        e = '{default: 0}; e.addr = 32'h100; e.be = 4'b1000; e.rdata = 32'hFFFFFF80; e.stall = 3; e.valid = 1;
        sb.push_back(e);
        run_access(32'h103, 32'h0, 0, 1, 0, 1, 0, 0, 0, 0, 32'h8000_0000, 0, o);
        e = sb.pop_front();
        checks++; if (o.addr !== e.addr) begin errors++; $display("FAIL lb_addr: got %h expected %h", o.addr, e.addr); end
        checks++; if (o.be !== e.be) begin errors++; $display("FAIL lb_be: got %b expected %b", o.be, e.be); end
        checks++; if (o.we !== 1'b0) begin errors++; $display("FAIL lb_we: got %b expected 0", o.we); end
        checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL lb_rdata: got %h expected %h", o.rdata, e.rdata); end
        checks++; if (o.stall != e.stall) begin errors++; $display("FAIL lb_stall: got %0d expected %0d", o.stall, e.stall); end
    endtask

    task automatic test_store_half();
        obs_t o, e;
        e = '{default: 0}; e.addr = 32'h200; e.be = 4'b1100; e.wdata = 32'hBEEFBEEF; e.we = 1; e.stall = 4; e.valid = 3;
        sb.push_back(e);
        run_access(32'h202, 32'h0000BEEF, 1, 0, 0, 0, 1, 0, 2, 0, 32'h0, 0, o);
        e = sb.pop_front();
        checks++; if (o.addr !== e.addr) begin errors++; $display("FAIL sh_addr: got %h expected %h", o.addr, e.addr); end
        checks++; if (o.be !== e.be) begin errors++; $display("FAIL sh_be: got %b expected %b", o.be, e.be); end
        checks++; if (o.wdata !== e.wdata) begin errors++; $display("FAIL sh_wdata: got %h expected %h", o.wdata, e.wdata); end
        checks++; if (o.we !== e.we) begin errors++; $display("FAIL sh_we: got %b expected %b", o.we, e.we); end
        checks++; if (o.unstable !== 1'b0) begin errors++; $display("FAIL sh_stable: got unstable=%b expected 0", o.unstable); end
        checks++; if (o.valid != e.valid) begin errors++; $display("FAIL sh_valid_cycles: got %0d expected %0d", o.valid, e.valid); end
        checks++; if (o.stall != e.stall) begin errors++; $display("FAIL sh_stall: got %0d expected %0d", o.stall, e.stall); end
    endtask

    task automatic test_store_byte();
        obs_t o, e;
        e = '{default: 0}; e.addr = 32'h104; e.be = 4'b0010; e.wdata = 32'h78787878; e.stall = 2;
        sb.push_back(e);
        run_access(32'h105, 32'h12345678, 1, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0, o);
        e = sb.pop_front();
        checks++; if (o.addr !== e.addr) begin errors++; $display("FAIL sb_addr: got %h expected %h", o.addr, e.addr); end
        checks++; if (o.be !== e.be) begin errors++; $display("FAIL sb_be: got %b expected %b", o.be, e.be); end
        checks++; if (o.wdata !== e.wdata) begin errors++; $display("FAIL sb_wdata: got %h expected %h", o.wdata, e.wdata); end
        checks++; if (o.stall != e.stall) begin errors++; $display("FAIL sb_stall: got %0d expected %0d", o.stall, e.stall); end
    endtask

    task automatic test_misalign();
        obs_t o, e;
        for (int i = 0; i < 2; i++) begin
            e = '{default: 0}; e.misalign = 1;
            sb.push_back(e);
            run_access(32'h301, 32'h0, 0, 1, 0, 0, i[0], ~i[0], 0, 0, 32'h0, 0, o);
            e = sb.pop_front();
            checks++; if (o.misalign !== e.misalign) begin errors++; $display("FAIL misalign_pulse[%0d]: got %b expected %b", i, o.misalign, e.misalign); end
            checks++; if (o.stall != e.stall) begin errors++; $display("FAIL misalign_stall[%0d]: got %0d expected %0d", i, o.stall, e.stall); end
            checks++; if (o.valid != e.valid) begin errors++; $display("FAIL misalign_bus[%0d]: got %0d valid cycles expected %0d", i, o.valid, e.valid); end
        end
    endtask

    task automatic test_load_half();
        obs_t o, e;
        logic [31:0] exp_rd [2] = '{32'h0000F00D, 32'hFFFFF00D};
        for (int i = 0; i < 2; i++) begin
            e = '{default: 0}; e.addr = 32'h10; e.be = 4'b1100; e.rdata = exp_rd[i]; e.stall = 3;
            sb.push_back(e);
            run_access(32'h12, 32'h0, 0, 1, ~i[0], 0, 1, 0, 0, 0, 32'hF00D_0000, 0, o);
            e = sb.pop_front();
            checks++; if (o.be !== e.be) begin errors++; $display("FAIL lh_be[%0d]: got %b expected %b", i, o.be, e.be); end
            checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL lh_rdata[%0d]: got %h expected %h", i, o.rdata, e.rdata); end
        end
    endtask

    task automatic test_load_word();
        obs_t o, e;
        e = '{default: 0}; e.addr = 32'h40; e.be = 4'b1111; e.rdata = 32'hDEADBEEF; e.stall = 5;
        sb.push_back(e);
        run_access(32'h40, 32'h0, 0, 1, 0, 0, 0, 1, 0, 2, 32'hDEADBEEF, 0, o);
        e = sb.pop_front();
        checks++; if (o.be !== e.be) begin errors++; $display("FAIL lw_be: got %b expected %b", o.be, e.be); end
        checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL lw_rdata: got %h expected %h", o.rdata, e.rdata); end
        checks++; if (o.stall != e.stall) begin errors++; $display("FAIL lw_stall: got %0d expected %0d", o.stall, e.stall); end
    endtask

    task automatic test_rw_both();
        obs_t o, e;
        e = '{default: 0}; e.addr = 32'h80; e.be = 4'b1111; e.wdata = 32'hCAFE0001; e.we = 1; e.rdata = 32'h0; e.stall = 2;
        sb.push_back(e);
        run_access(32'h80, 32'hCAFE0001, 1, 1, 0, 0, 0, 0, 0, 0, 32'h11111111, 0, o);
        e = sb.pop_front();
        checks++; if (o.we !== e.we) begin errors++; $display("FAIL rw_we: got %b expected %b", o.we, e.we); end
        checks++; if (o.be !== e.be) begin errors++; $display("FAIL rw_be: got %b expected %b", o.be, e.be); end
        checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL rw_rdata: got %h expected %h", o.rdata, e.rdata); end
        checks++; if (o.stall != e.stall) begin errors++; $display("FAIL rw_stall: got %0d expected %0d", o.stall, e.stall); end
    endtask

    task automatic test_timeout();
        obs_t o, e;
        e = '{default: 0}; e.fault = 1; e.rdata = 32'h0; e.stall = 5; e.valid = 4;
        sb.push_back(e);
        run_access(32'h500, 32'h0, 0, 1, 0, 0, 0, 1, -1, 0, 32'h0, 0, o);
        e = sb.pop_front();
        checks++; if (o.valid != e.valid) begin errors++; $display("FAIL to_valid_cycles: got %0d expected %0d", o.valid, e.valid); end
        checks++; if (o.fault !== e.fault) begin errors++; $display("FAIL to_fault: got %b expected %b", o.fault, e.fault); end
        checks++; if (o.fault_next !== 1'b0) begin errors++; $display("FAIL to_fault_pulse: got %b expected 0", o.fault_next); end
        checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL to_rdata: got %h expected %h", o.rdata, e.rdata); end
        checks++; if (o.stall != e.stall) begin errors++; $display("FAIL to_stall: got %0d expected %0d", o.stall, e.stall); end
    endtask

    task automatic test_bus_err();
        obs_t o, e;
        e = '{default: 0}; e.fault = 1; e.stall = 2;
        sb.push_back(e);
        run_access(32'h400, 32'h5A5A5A5A, 1, 0, 0, 0, 0, 1, 0, 0, 32'h0, 1, o);
        e = sb.pop_front();
        checks++; if (o.fault !== e.fault) begin errors++; $display("FAIL werr_fault: got %b expected %b", o.fault, e.fault); end
        checks++; if (o.stall != e.stall) begin errors++; $display("FAIL werr_stall: got %0d expected %0d", o.stall, e.stall); end
        e = '{default: 0}; e.fault = 1; e.rdata = 32'h0; e.stall = 3;
        sb.push_back(e);
        run_access(32'h404, 32'h0, 0, 1, 0, 0, 0, 1, 0, 0, 32'h77777777, 1, o);
        e = sb.pop_front();
        checks++; if (o.fault !== e.fault) begin errors++; $display("FAIL rerr_fault: got %b expected %b", o.fault, e.fault); end
        checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL rerr_rdata: got %h expected %h", o.rdata, e.rdata); end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        logic [31:0] a [3] = '{32'h101, 32'h22, 32'h30};
        logic [31:0] r [3] = '{32'h0000A500, 32'h80010000, 32'h12345678};
        logic [31:0] x [3] = '{32'h000000A5, 32'hFFFF8001, 32'h12345678};
        logic [2:0] sz [3] = '{3'b100, 3'b010, 3'b001};
        for (int i = 0; i < 3; i++) begin
            e = '{default: 0}; e.rdata = x[i]; e.stall = 4;
            sb.push_back(e);
        end
        for (int i = 0; i < 3; i++) begin
            run_access(a[i], 32'h0, 0, 1, i == 0, sz[i][2], sz[i][1], sz[i][0], 1, 0, r[i], 0, o);
            e = sb.pop_front();
            checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", i, o.rdata, e.rdata); end
            checks++; if (o.fault !== 1'b0) begin errors++; $display("FAIL b2b_fault[%0d]: got %b expected 0", i, o.fault); end
            checks++; if (o.stall != e.stall) begin errors++; $display("FAIL b2b_stall[%0d]: got %0d expected %0d", i, o.stall, e.stall); end
        end
    endtask

    task automatic test_reset_resp();
        @(posedge clk); #1;
        dmem_addr = 32'h600; dmem_read = 1; dmem_write = 0; dmem_wrd = 1; dmem_byte = 0; dmem_hwrd = 0; dmem_rdu = 0;
        bus_rdata = 32'h5555AAAA;
        @(posedge clk); #1;
        checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL rr_req_valid: got %b expected 1", bus_valid); end
        bus_ready = 1;
        @(posedge clk); #1;
        bus_ready = 0;
        checks++; if (dmem_stall !== 1'b1 || bus_valid !== 1'b0) begin errors++; $display("FAIL rr_resp: got stall=%b valid=%b expected 1/0", dmem_stall, bus_valid); end
        rst = 1; dmem_read = 0; dmem_wrd = 0;
        #2 rst = 0;
        #1 bus_rvalid = 1;
        @(posedge clk); #1;
        bus_rvalid = 0;
        #1;
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL rr_valid: got %b expected 0", bus_valid); end
        checks++; if (dmem_stall !== 1'b0) begin errors++; $display("FAIL rr_stall: got %b expected 0", dmem_stall); end
        checks++; if (dmem_rdata !== 32'h0) begin errors++; $display("FAIL rr_rdata: got %h expected 0", dmem_rdata); end
        checks++; if (dmem_fault !== 1'b0) begin errors++; $display("FAIL rr_fault: got %b expected 0", dmem_fault); end
        @(posedge clk); #2;
        checks++; if (bus_valid !== 1'b0 || dmem_rdata !== 32'h0 || dmem_fault !== 1'b0) begin errors++; $display("FAIL rr_idle: got valid=%b rdata=%h fault=%b expected 0/0/0", bus_valid, dmem_rdata, dmem_fault); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #3 rst = 0;
        #1;
        test_reset();
        test_load_byte();
        test_store_half();
        test_store_byte();
        test_misalign();
        test_load_half();
        test_load_word();
        test_rw_both();
        test_timeout();
        test_bus_err();
        test_back_to_back();
        test_reset_resp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
